// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-high, bit 0 = segment a .. bit 6 = segment g.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam logic [3:0] COM_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Entry 15 is listed first: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ssd_hex_decode.sv
// Hex nibble to seven-segment pattern; purely combinational table lookup.
// No latency, no flow control.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with dead-time blanking and leading-zero suppression.
// All outputs registered (one cycle from state decision); the write port is always accepted and never stalls.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int CLK_DIV   = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic       Clk,
    input  logic       Aclr,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       lz_sup,
    output logic [3:0] COM,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       idx_nxt;

    logic [3:0][3:0]  digit_reg;
    logic [3:0]       dp_reg;

    logic [6:0]       dec_seg;
    logic             lz_blank;
    logic             slot_latch;

    ssd_hex_decode u_dec (
        .hex (digit_reg[digit_idx]),
        .seg (dec_seg)
    );

    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            digit_reg <= '0;
            dp_reg    <= '0;
        end else if (wr_en) begin
            digit_reg[wr_addr] <= wr_data;
            dp_reg[wr_addr]    <= wr_dp;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = digit_idx;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_nxt = ON;
                    end
                end
                ON: begin
                    if (cnt == SLOT_LAST) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        idx_nxt   = digit_idx + 2'd1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign slot_latch = (state == BLANK) && (state_nxt == ON);

    // Suppression looks only at the more significant digits; digit 0 is always shown.
    always_comb begin
        lz_blank = 1'b0;
        if (lz_sup) begin
            case (digit_idx)
                2'd3:    lz_blank = (digit_reg[3] == 4'd0);
                2'd2:    lz_blank = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0);
                2'd1:    lz_blank = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0) &&
                                    (digit_reg[1] == 4'd0);
                default: lz_blank = 1'b0;
            endcase
        end
    end

    // Output registers are loaded from next-state so COM tracks the ON state cycle-exactly.
    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            state      <= IDLE;
            cnt        <= '0;
            digit_idx  <= 2'd0;
            COM        <= COM_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit_idx  <= idx_nxt;
            frame_tick <= slot_latch && (digit_idx == 2'd0);
            if (state_nxt == ON) begin
                COM <= ~(4'b0001 << idx_nxt);
            end else begin
                COM <= COM_OFF;
            end
            if (slot_latch) begin
                seg <= lz_blank ? SEG_OFF : dec_seg;
                dp  <= dp_reg[digit_idx];
            end else if (state_nxt != ON) begin
                seg <= SEG_OFF;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with CLK_DIV=8, BLANK_CYC=2 (frame = 32 cycles).
module tb_ssd_scan_ctrl;

    logic       Clk;
    logic       Aclr;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       lz_sup;
    logic [3:0] COM;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_scan_ctrl #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
        .Clk        (Clk),
        .Aclr       (Aclr),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .lz_sup     (lz_sup),
        .COM        (COM),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // At most one common may be low in any cycle while out of reset.
    always @(negedge Clk) begin
        if (Aclr) begin
            check_eq("com_onehot", 32'($countones(~COM) > 1), 32'd0);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic p);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_dp   = p;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_com"}, 32'(COM), 32'hF);
        check_eq({tag, "_seg"}, 32'(seg), 32'h0);
        check_eq({tag, "_dp"},  32'(dp),  32'h0);
        check_eq({tag, "_idx"}, 32'(digit_idx), 32'h0);
        check_eq({tag, "_ft"},  32'(frame_tick), 32'h0);
    endtask

    // One full frame starting at the edge that enters slot 0 BLANK.
    // Optional write (wcyc >= 0) is presented on the edge of cycle wcyc.
    task automatic run_frame(input logic [3:0][6:0] es, input logic [3:0] edp,
                             input int wcyc, input logic [1:0] wa, input logic [3:0] wd);
        logic [3:0] ecom;
        int s;
        int c;
        for (int i = 0; i < 32; i++) begin
            if (i == wcyc) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
                wr_dp   = 1'b0;
            end
            tick();
            wr_en = 1'b0;
            s = i / 8;
            c = i % 8;
            ecom = 4'hF;
            if (c >= 2) ecom[s] = 1'b0;
            check_eq($sformatf("com s%0d c%0d", s, c), 32'(COM), 32'(ecom));
            check_eq($sformatf("seg s%0d c%0d", s, c), 32'(seg), (c >= 2) ? 32'(es[s]) : 32'h0);
            check_eq($sformatf("dp s%0d c%0d", s, c), 32'(dp), (c >= 2) ? 32'(edp[s]) : 32'h0);
            check_eq($sformatf("idx s%0d c%0d", s, c), 32'(digit_idx), 32'(s));
            check_eq($sformatf("ft s%0d c%0d", s, c), 32'(frame_tick), 32'(i == 2));
        end
    endtask

    initial begin
        int ft_seen;
        Aclr    = 1'b0;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'd0;
        wr_dp   = 1'b0;
        lz_sup  = 1'b0;

        // Reset and idle with enable low.
        #12;
        check_dark("rst");
        Aclr = 1'b1;
        ft_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (frame_tick) ft_seen++;
        end
        check_eq("idle_ft_count", 32'(ft_seen), 32'd0);
        check_dark("idle");

        // Basic scan of 1,2,3,4; two frames prove the 32-cycle frame_tick period.
        wr(2'd0, 4'h1, 1'b0);
        wr(2'd1, 4'h2, 1'b0);
        wr(2'd2, 4'h3, 1'b0);
        wr(2'd3, 4'h4, 1'b0);
        enable = 1'b1;
        run_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, -1, 2'd0, 4'h0);
        run_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, -1, 2'd0, 4'h0);

        // Write digit 2 during its lit period: held until the next frame.
        run_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, 20, 2'd2, 4'hA);
        // Write on the latch edge itself: the latch sees the old value.
        run_frame({7'h66, 7'h77, 7'h5B, 7'h06}, 4'b0000, 18, 2'd2, 4'h5);
        run_frame({7'h66, 7'h6D, 7'h5B, 7'h06}, 4'b0000, -1, 2'd0, 4'h0);

        // Drop enable during digit 1's lit period.
        for (int i = 0; i < 11; i++) tick();
        check_eq("pre_drop_com", 32'(COM), 32'hD);
        check_eq("pre_drop_seg", 32'(seg), 32'h5B);
        enable = 1'b0;
        tick();
        check_dark("drop");
        for (int i = 0; i < 3; i++) tick();
        check_dark("drop_idle");
        enable = 1'b1;
        run_frame({7'h66, 7'h6D, 7'h5B, 7'h06}, 4'b0000, -1, 2'd0, 4'h0);

        // Enable falls on the same edge as a write: write lands, display goes dark.
        enable = 1'b0;
        wr(2'd3, 4'h0, 1'b0);
        check_dark("drop_wr");
        wr(2'd2, 4'h0, 1'b0);
        wr(2'd1, 4'h7, 1'b1);
        wr(2'd0, 4'h0, 1'b0);
        lz_sup = 1'b1;
        enable = 1'b1;
        run_frame({7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0010, -1, 2'd0, 4'h0);
        lz_sup = 1'b0;
        run_frame({7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0010, -1, 2'd0, 4'h0);

        // Asynchronous reset mid-frame, applied between clock edges.
        lz_sup = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_eq("pre_rst_com", 32'(COM), 32'hB);
        #3;
        Aclr = 1'b0;
        #1;
        check_dark("arst");
        #2;
        Aclr = 1'b1;
        run_frame({7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, -1, 2'd0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Scan controller for the 4-digit multiplexed seven-segment display. It holds four hex digit registers and a decimal-point register, written through a simple write port. It time-multiplexes the common lines with a programmable slot length and dead-time blanking. It decodes the selected digit to segments, with optional leading-zero suppression, and replaces the free-running counter plus 3-to-8 decoder scan path in the display top level.

Parameters:
CLK_DIV, 1000, Clk cycles per digit slot; legal range is 3 to 65535.
BLANK_CYC, 16, dead-time cycles at the start of each slot; legal range is 1 to CLK_DIV-2.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Aclr  input  1  asynchronous active-low reset.
enable  input  1  scan enable; low forces the display dark.
wr_en  input  1  digit register write strobe, single cycle.
wr_addr  input  2  digit index to write; 0 is least significant, 3 is most significant.
wr_data  input  4  hex value 0..F.
wr_dp  input  1  decimal-point bit for the addressed digit.
lz_sup  input  1  leading-zero suppression enable.
COM  output  4  digit commons, active-low, one-hot-low when lit.
seg  output  7  segments, active-high; seg[0]=a .. seg[6]=g.
dp  output  1  decimal point, active-high.
digit_idx  output  2  index of the current slot.
frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (Aclr low, asynchronous):
  - COM=4'hF, seg=0, dp=0, digit_idx=0, frame_tick=0.
  - All digit registers and dp registers are cleared to 0.
  - Slot counter is cleared to 0. State is IDLE.
- States:
  - IDLE: dark (COM=4'hF, seg=0, dp=0).
  - BLANK: dark, slot counter cnt < BLANK_CYC.
  - ON: COM[digit_idx]=0, all other COM bits high, seg/dp driven from the slot latch.
- Transitions:
  - IDLE -> BLANK when enable=1, with cnt=0 and digit_idx=0.
  - BLANK -> ON on the edge where cnt reaches BLANK_CYC.
  - ON -> BLANK on the edge after cnt=CLK_DIV-1. cnt returns to 0 and digit_idx increments modulo 4 (3 wraps to 0).
  - Any state -> IDLE on the next edge when enable=0. cnt and digit_idx clear to 0.
- Slot timing:
  - Each slot is exactly CLK_DIV cycles: BLANK_CYC dark cycles, then CLK_DIV-BLANK_CYC lit cycles.
  - A frame is 4*CLK_DIV cycles.
  - Slots never overlap: at most one COM bit is low in any cycle.
- Outputs: all outputs are registered, with no combinational path from inputs to outputs.
- Slot latch:
  - On the BLANK -> ON edge, the controller captures decode(reg[digit_idx]) and dp_reg[digit_idx] into the seg/dp output registers.
  - These values hold for the whole lit period.
  - A write to the digit being lit appears only at that digit's next slot.
- Writes:
  - When wr_en=1, reg[wr_addr] and dp_reg[wr_addr] update on that edge.
  - Writes are accepted in every state, including IDLE.
  - There is no ready signal; the write port never stalls.
- Decode (hex, seg[6:0] = g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero suppression (lz_sup=1, evaluated at slot latch):
  - Digit 3 is blank if reg3=0.
  - Digit 2 is blank if reg3=reg2=0.
  - Digit 1 is blank if reg3=reg2=reg1=0.
  - Digit 0 is never blanked.
  - A suppressed digit drives seg=0 but still drives dp from its dp_reg, and its COM still goes low.
- frame_tick: high for exactly the one cycle following the BLANK -> ON edge of digit 0.
- Simultaneous events:
  - If enable falls on the same edge as a write, the write completes and the state goes to IDLE.
  - A write and the slot latch hitting the same register on the same edge: the latch takes the old value.
- Reset mid-slot: outputs go dark immediately. After release, the sequence restarts from IDLE.

Decomposition:
- Shared package ssd_pkg holds:
  - a state enum (IDLE, BLANK, ON);
  - the 16-entry hex-to-segment constant table;
  - the constants COM_OFF=4'hF and SEG_OFF=7'h00.
- One sub-module, ssd_hex_decode: 4-bit input, 7-bit output, purely combinational, table lookup from the package.
- Slot counter width is $clog2(CLK_DIV).

Test Plan:
1. Reset release, enable=0, 100 cycles -> COM=F, seg=00, dp=0, frame_tick never asserted.
2. CLK_DIV=8, BLANK_CYC=2; write digits 0..3 = 1,2,3,4; enable=1 -> per slot: 2 cycles COM=F, then 6 cycles lit.
   - Lit slots in order: COM=E seg=06, COM=D seg=5B, COM=B seg=4F, COM=7 seg=66.
   - frame_tick period is 32 cycles.
   - A checker flags any cycle with more than one COM bit low.
3. Digits {3..0}=0,0,7,0 with dp1=1 and lz_sup=1:
   - Digits 3 and 2 show seg=00 (COM still cycles).
   - Digit 1 shows seg=07, dp=1.
   - Digit 0 shows seg=3F.
   - With lz_sup=0, digits 3 and 2 show 3F.
4. Write digit 2=A in the middle of digit 2's lit period -> seg stays 4F until the slot ends; next frame shows 77.
5. Drop enable in the middle of a lit period -> next cycle COM=F, seg=00, digit_idx=0. Re-enable -> first lit slot is digit 0, after BLANK_CYC cycles.
6. Assert Aclr in the middle of a frame, asynchronously between edges -> outputs dark without waiting for Clk; digit registers read 0 (seg=3F on digit 0 after re-enable).
